// File: rtl/debug_display.sv
// debug_display: single-step button conditioning and 4-digit hex readout of pipeline PC/register values
module debug_display #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REFRESH_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btnStep,
   input  logic        run,
   input  logic        mode,
   input  logic        halfSel,
   input  logic [4:0]  select,
   input  logic [31:0] pcOut,
   input  logic [31:0] regOut,
   output logic [4:0]  regIn,
   output logic        stepEn,
   output logic [3:0]  anode,
   output logic [6:0]  segment
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   logic [31:0]   shadow_q, shadow_d;
   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic          stable_q, stable_d, stable_dly_q, stable_dly_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          step_pulse_q, step_pulse_d;
   logic [RW-1:0] refresh_q, refresh_d;
   logic [1:0]    digit_q, digit_d;
   logic          wrap;
   logic [3:0]    nibble;

   assign regIn  = select;
   assign stepEn = run | step_pulse_q;
   assign anode  = ~(4'b0001 << digit_q);
   assign nibble = shadow_q[{halfSel, digit_q, 2'b00} +: 4];
   assign wrap   = refresh_q == RW'(REFRESH_CYCLES - 1);

   // next state: shadow capture, button sync/debounce, rising-edge pulse, digit scan
   always_comb begin
      shadow_d     = mode ? regOut : pcOut;
      sync1_d      = btnStep;
      sync2_d      = sync1_q;
      stable_d     = stable_q;
      cnt_d        = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q + 1'b1 == CW'(DEBOUNCE_CYCLES)) stable_d = sync2_q;
         else cnt_d = cnt_q + 1'b1;
      end
      stable_dly_d = stable_q;
      step_pulse_d = stable_q & ~stable_dly_q;
      refresh_d    = wrap ? '0 : refresh_q + 1'b1;
      digit_d      = digit_q + {1'b0, wrap};
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q     <= '0;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         cnt_q        <= '0;
         step_pulse_q <= 1'b0;
         refresh_q    <= '0;
         digit_q      <= '0;
      end else begin
         shadow_q     <= shadow_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         cnt_q        <= cnt_d;
         step_pulse_q <= step_pulse_d;
         refresh_q    <= refresh_d;
         digit_q      <= digit_d;
      end
   end

   // active-low gfedcba hex decode of the selected nibble
   always_comb begin
      segment = 7'b1111111;
      case (nibble)
         4'h0: segment = 7'b1000000;
         4'h1: segment = 7'b1111001;
         4'h2: segment = 7'b0100100;
         4'h3: segment = 7'b0110000;
         4'h4: segment = 7'b0011001;
         4'h5: segment = 7'b0010010;
         4'h6: segment = 7'b0000010;
         4'h7: segment = 7'b1111000;
         4'h8: segment = 7'b0000000;
         4'h9: segment = 7'b0010000;
         4'hA: segment = 7'b0001000;
         4'hB: segment = 7'b0000011;
         4'hC: segment = 7'b1000110;
         4'hD: segment = 7'b0100001;
         4'hE: segment = 7'b0000110;
         default: segment = 7'b0001110;
      endcase
   end
endmodule
